// File: rtl/ring_buffer_hs.sv
`default_nettype none
// ============================================================================
//  Module   : ring_buffer_hs
//  Purpose  : Parametrised ring buffer with valid/ready handshakes on both
//             sides. Words are stored in a DEPTH-entry register array and
//             presented oldest-first (show-ahead). OVERWRITE selects between
//             back-pressuring the writer when full (0) and discarding the
//             oldest entry to make room (1).
//  Ports    : clk, rst_n           - clock, asynchronous active-low reset
//             flush                - synchronous empty, highest priority
//             wr_valid/wr_ready/wr_data - write handshake
//             rd_valid/rd_ready/rd_data - read handshake (show-ahead)
//             level/full/empty     - occupancy status
//             wr_cnt               - accepted writes, wraps
//             drop_cnt             - overwritten entries, saturates
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module ring_buffer_hs #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter bit          OVERWRITE = 1'b0,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       wr_valid,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       wr_ready,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [DATA_W-1:0]          rd_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty,
  output logic [CNT_W-1:0]           wr_cnt,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int unsigned     AW      = $clog2(DEPTH);
  localparam logic [AW:0]     LVL_MAX = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q,   rd_ptr_d;
  logic [AW:0]      level_q,    level_d;
  logic [CNT_W-1:0] wr_cnt_q,   wr_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  // Low during reset and until the first edge afterwards, so the writer is
  // never told "ready" while the buffer is held in reset.
  logic             ready_q;

  logic wr_fire;
  logic rd_fire;
  logic full_w;
  logic empty_w;

  assign full_w  = (level_q == LVL_MAX);
  assign empty_w = (level_q == '0);

  generate
    if (OVERWRITE) begin : g_overwrite
      assign wr_ready = ready_q;
    end else begin : g_backpressure
      assign wr_ready = ready_q & ~full_w;
    end
  endgenerate

  assign rd_valid = ~empty_w;
  assign wr_fire  = wr_valid & wr_ready;
  assign rd_fire  = rd_valid & rd_ready;

  // Array contents are never cleared; masking on empty hides stale words.
  assign rd_data  = empty_w ? '0 : mem[rd_ptr_q];
  assign level    = level_q;
  assign full     = full_w;
  assign empty    = empty_w;
  assign wr_cnt   = wr_cnt_q;
  assign drop_cnt = drop_cnt_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    wr_cnt_d   = wr_cnt_q;
    drop_cnt_d = drop_cnt_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (wr_fire) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        wr_cnt_d = wr_cnt_q + CNT_W'(1);
      end
      if (rd_fire) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end

      if (wr_fire && !rd_fire) begin
        if (full_w) begin
          // Only reachable with OVERWRITE: the oldest slot is the one being
          // written, so the read side skips past it and occupancy holds.
          rd_ptr_d = rd_ptr_q + AW'(1);
          if (drop_cnt_q != '1) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
          end
        end else begin
          level_d = level_q + (AW+1)'(1);
        end
      end else if (rd_fire && !wr_fire) begin
        level_d = level_q - (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      wr_cnt_q   <= '0;
      drop_cnt_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      wr_cnt_q   <= wr_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      ready_q    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire && !flush) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ring_buffer_hs.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ring_buffer_hs
//  Purpose  : Self-checking bench for ring_buffer_hs. Three instances share
//             one stimulus stream: back-pressure (u0), overwrite (u1) and
//             overwrite with 2-bit counters (u2). A queue-style model per
//             instance is compared every cycle; literal checks pin the model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ring_buffer_hs;

  localparam int N  = 3;
  localparam int DP = 16;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       rd_ready;

  logic       wrr [N];
  logic       rdv [N];
  logic [7:0] rdd [N];
  logic [4:0] lvl [N];
  logic       fu  [N];
  logic       em  [N];
  logic [7:0] wc0, wc1, dc0, dc1;
  logic [1:0] wc2, dc2;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  // Model state: element 0 of mq[k] is always the oldest word.
  logic [7:0] mq [N][DP];
  int         mlen  [N];
  int         mwr   [N];
  int         mdrop [N];
  bit         mrdy;

  ring_buffer_hs #(.DATA_W(8), .DEPTH(16), .OVERWRITE(1'b0), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wrr[0]), .rd_valid(rdv[0]), .rd_ready(rd_ready), .rd_data(rdd[0]),
    .level(lvl[0]), .full(fu[0]), .empty(em[0]), .wr_cnt(wc0), .drop_cnt(dc0));

  ring_buffer_hs #(.DATA_W(8), .DEPTH(16), .OVERWRITE(1'b1), .CNT_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wrr[1]), .rd_valid(rdv[1]), .rd_ready(rd_ready), .rd_data(rdd[1]),
    .level(lvl[1]), .full(fu[1]), .empty(em[1]), .wr_cnt(wc1), .drop_cnt(dc1));

  ring_buffer_hs #(.DATA_W(8), .DEPTH(16), .OVERWRITE(1'b1), .CNT_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wrr[2]), .rd_valid(rdv[2]), .rd_ready(rd_ready), .rd_data(rdd[2]),
    .level(lvl[2]), .full(fu[2]), .empty(em[2]), .wr_cnt(wc2), .drop_cnt(dc2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit ovw(input int k);
    return (k != 0);
  endfunction

  function automatic int cmax(input int k);
    return (k == 2) ? 3 : 255;
  endfunction

  function automatic int wcnt(input int k);
    case (k)
      0:       return int'(wc0);
      1:       return int'(wc1);
      default: return int'(wc2);
    endcase
  endfunction

  function automatic int dcnt(input int k);
    case (k)
      0:       return int'(dc0);
      1:       return int'(dc1);
      default: return int'(dc2);
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  task automatic pop(input int k);
    for (int i = 0; i < DP-1; i++) mq[k][i] = mq[k][i+1];
    mlen[k]--;
  endtask

  task automatic model_step();
    bit wf;
    bit rf;
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        mlen[k] = 0; mwr[k] = 0; mdrop[k] = 0;
      end
      mrdy = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        wf = wr_valid && mrdy && (ovw(k) || mlen[k] < DP);
        rf = rd_ready && (mlen[k] > 0);
        if (flush) begin
          mlen[k] = 0;
        end else begin
          if (rf) pop(k);
          if (wf) begin
            if (mlen[k] == DP) begin
              pop(k);
              if (mdrop[k] < cmax(k)) mdrop[k]++;
            end
            mq[k][mlen[k]] = wr_data;
            mlen[k]++;
            mwr[k] = (mwr[k] + 1) % (cmax(k) + 1);
          end
        end
      end
      mrdy = 1;
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      mlen[k] = 0; mwr[k] = 0; mdrop[k] = 0;
    end
    mrdy = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  task automatic compare_all();
    int  exp_rd;
    bit  exp_wr_rdy;
    for (int k = 0; k < N; k++) begin
      exp_rd     = (mlen[k] > 0) ? int'(mq[k][0]) : 0;
      exp_wr_rdy = mrdy && (ovw(k) || mlen[k] < DP);
      chk($sformatf("u%0d level", k),    int'(lvl[k]), mlen[k]);
      chk($sformatf("u%0d full", k),     int'(fu[k]),  int'(mlen[k] == DP));
      chk($sformatf("u%0d empty", k),    int'(em[k]),  int'(mlen[k] == 0));
      chk($sformatf("u%0d rd_valid", k), int'(rdv[k]), int'(mlen[k] > 0));
      chk($sformatf("u%0d rd_data", k),  int'(rdd[k]), exp_rd);
      chk($sformatf("u%0d wr_ready", k), int'(wrr[k]), int'(exp_wr_rdy));
      chk($sformatf("u%0d wr_cnt", k),   wcnt(k),      mwr[k]);
      chk($sformatf("u%0d drop_cnt", k), dcnt(k),      mdrop[k]);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) compare_all();
    end
  end

  // Drive one cycle of inputs, wait until the following negedge, then idle.
  task automatic cyc(input logic wv, input logic [7:0] wd, input logic rr, input logic fl);
    wr_valid = wv; wr_data = wd; rd_ready = rr; flush = fl;
    @(negedge clk);
    wr_valid = 1'b0; rd_ready = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; flush = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    #1 rst_n = 1'b0;
    cmp_en = 1;
    repeat (2) @(negedge clk);

    // Reset state
    for (int k = 0; k < N; k++) begin
      chk("reset level",    int'(lvl[k]), 0);
      chk("reset wr_ready", int'(wrr[k]), 0);
      chk("reset rd_data",  int'(rdd[k]), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("wr_ready after first edge", int'(wrr[0]), 1);

    // Fill 0x00..0x0F, then four more writes (rejected by u0, overwrite in u1/u2)
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    chk("u0 full after fill",  int'(fu[0]),  1);
    chk("u0 level after fill", int'(lvl[0]), 16);
    chk("u0 wr_ready full",    int'(wrr[0]), 0);
    for (int i = 16; i < 20; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    chk("u0 wr_cnt blocked",   int'(wc0),    16);
    chk("u1 level overwrite",  int'(lvl[1]), 16);
    chk("u1 drop_cnt",         int'(dc1),    4);
    chk("u1 wr_cnt",           int'(wc1),    20);
    chk("u1 oldest",           int'(rdd[1]), 8'h04);
    chk("u2 drop_cnt sat",     int'(dc2),    3);
    chk("u2 wr_cnt wrap",      int'(wc2),    0);

    // Drain order
    for (int i = 0; i < 16; i++) begin
      chk("u0 drain data", int'(rdd[0]), i);
      chk("u1 drain data", int'(rdd[1]), 4 + i);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("u0 empty after drain",   int'(em[0]),  1);
    chk("u0 rd_data after drain", int'(rdd[0]), 0);
    chk("u0 rd_valid after drain",int'(rdv[0]), 0);

    // Refill, then one cycle with both handshakes at full
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'hAA, 1'b1, 1'b0);
    chk("u1 drop unchanged both", int'(dc1),    4);
    chk("u1 level both",          int'(lvl[1]), 16);
    chk("u1 oldest advanced",     int'(rdd[1]), 8'h21);
    chk("u0 level read at full",  int'(lvl[0]), 15);

    // Flush with a write in the same cycle
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    chk("level before flush", int'(lvl[0]), 5);
    cyc(1'b1, 8'h99, 1'b0, 1'b1);
    chk("u0 level flushed",   int'(lvl[0]), 0);
    chk("u0 empty flushed",   int'(em[0]),  1);
    chk("u0 wr_cnt flush",    int'(wc0),    37);
    chk("u1 wr_cnt flush",    int'(wc1),    42);
    cyc(1'b1, 8'h55, 1'b0, 1'b0);
    chk("post-flush rd_data",  int'(rdd[1]), 8'h55);
    chk("post-flush rd_valid", int'(rdv[1]), 1);

    // Stream at level 7, then asynchronous reset between edges
    for (int i = 0; i < 6; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'h66, 1'b1, 1'b0);
    chk("stream level", int'(lvl[0]), 7);
    wr_valid = 1'b1; wr_data = 8'h77; rd_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async level",    int'(lvl[1]), 0);
    chk("async rd_valid", int'(rdv[1]), 0);
    chk("async rd_data",  int'(rdd[1]), 0);
    chk("async wr_ready", int'(wrr[1]), 0);
    chk("async wr_cnt",   int'(wc1),    0);
    chk("async drop_cnt", int'(dc1),    0);
    @(negedge clk);
    wr_valid = 1'b0; rd_ready = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // Mixed traffic checked by the model
    for (int i = 0; i < 300; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 39) == 0));
    end

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
